ecc_mem_scrubber: RTL and testbench

//  Background scrubber for a SECDED-protected word memory (39-bit codeword = data[31:0] + check[38:32]).

---
 rtl/ecc_pkg.sv | 59 +++++
 rtl/ecc_secded_dec.sv | 40 ++++
 rtl/ecc_mem_scrubber.sv | 159 +++++++++++++++
 tb/tb_ecc_mem_scrubber.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: codeword layout, scrubber state encoding and the
// check-bit equations used by both the write-back encoder and the decoder.
package ecc_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int CODE_WIDTH  = 39;
  localparam int HAM_WIDTH   = 6;
  localparam int CHK_LSB     = DATA_WIDTH;
  localparam int PARITY_BIT  = CODE_WIDTH - 1;

  // Layout: [31:0] data, [37:32] Hamming check bits, [38] overall parity.
  typedef logic [CODE_WIDTH-1:0] codeword_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [HAM_WIDTH-1:0]  syndrome_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_CHK  = 3'd3,
    ST_WR   = 3'd4,
    ST_NEXT = 3'd5
  } scrub_state_e;

  // Hamming position of data bit k: the k-th non-power-of-two position >= 3.
  function automatic syndrome_t data_pos(input int k);
    int        cnt;
    syndrome_t pos;
    cnt = 0;
    pos = '0;
    for (int p = 3; p < CODE_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = HAM_WIDTH'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic syndrome_t calc_check(input data_t data);
    syndrome_t chk;
    syndrome_t pos;
    chk = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      pos = data_pos(k);
      for (int i = 0; i < HAM_WIDTH; i++) begin
        if (pos[i]) chk[i] = chk[i] ^ data[k];
      end
    end
    return chk;
  endfunction

  function automatic codeword_t encode(input data_t data);
    syndrome_t chk;
    chk = calc_check(data);
    return {^{chk, data}, chk, data};
  endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Combinational SECDED decoder: corrects any single-bit error and flags
// double-bit errors using the Hamming syndrome plus the overall parity bit.
module ecc_secded_dec
  import ecc_pkg::*;
(
  input  codeword_t code,
  output data_t     data,
  output logic      single_err,
  output logic      multi_err
);

  syndrome_t syn;
  logic      parity;

  always_comb begin
    syn        = calc_check(code[DATA_WIDTH-1:0]) ^ code[PARITY_BIT-1:CHK_LSB];
    parity     = ^code;
    data       = code[DATA_WIDTH-1:0];
    single_err = 1'b0;
    multi_err  = 1'b0;
    if (parity) begin
      // Zero or power-of-two syndrome: the flipped bit is a check/parity bit.
      if ((syn & (syn - 1'b1)) == '0) begin
        single_err = 1'b1;
      end else begin
        multi_err = 1'b1;
        for (int k = 0; k < DATA_WIDTH; k++) begin
          if (data_pos(k) == syn) begin
            data[k]    = ~code[k];
            single_err = 1'b1;
            multi_err  = 1'b0;
          end
        end
      end
    end else if (syn != '0) begin
      multi_err = 1'b1;
    end
  end

endmodule

// File: rtl/ecc_mem_scrubber.sv
// Background SECDED memory scrubber: reads every word, writes back corrected
// words, counts errors. Optional automatic passes under ECC_SCRUB_AUTO_EN.
//
// Memory handshake: a request (mem_req with mem_we/mem_addr/mem_wdata) is held
// stable until the cycle mem_req & mem_gnt, where it completes; mem_gnt alone
// is ignored. Read data is accepted only on mem_rvalid while waiting for it.
module ecc_mem_scrubber
  import ecc_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int CNT_W    = 16,
  parameter int INTERVAL = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output codeword_t         mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  codeword_t         mem_rdata,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic              ue_irq,
  output logic [ADDR_W-1:0] ue_addr,
  output scrub_state_e      dbg_state
);

  scrub_state_e      state, state_nxt;
  logic [ADDR_W-1:0] addr;
  codeword_t         rdata_q;
  codeword_t         wdata_q;
  data_t             corr_data;
  logic              single_err;
  logic              multi_err;
  logic              ue_seen;
  logic              done_q;
  logic              ue_irq_q;
  logic              auto_trig;
  logic              begin_pass;
  logic              last_addr;

  ecc_secded_dec u_dec (
    .code       (rdata_q),
    .data       (corr_data),
    .single_err (single_err),
    .multi_err  (multi_err)
  );

`ifdef ECC_SCRUB_AUTO_EN
  localparam int TMR_W = $clog2(INTERVAL + 1);
  logic [TMR_W-1:0] timer;

  // Held at INTERVAL outside IDLE so it starts fresh each time IDLE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= TMR_W'(INTERVAL);
    end else if (state != ST_IDLE || start) begin
      timer <= TMR_W'(INTERVAL);
    end else if (timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

  assign auto_trig = (state == ST_IDLE) && (timer == '0);
`else
  assign auto_trig = 1'b0;
`endif

  assign begin_pass = (state == ST_IDLE) && (start || auto_trig);
  assign last_addr  = (addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE: if (begin_pass) state_nxt = ST_RD;
      ST_RD: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = ST_WAIT;
      end
      ST_WAIT: if (mem_rvalid) state_nxt = ST_CHK;
      ST_CHK:  state_nxt = single_err ? ST_WR : ST_NEXT;
      ST_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) state_nxt = ST_NEXT;
      end
      ST_NEXT: state_nxt = last_addr ? ST_IDLE : ST_RD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      ce_count <= '0;
      ue_count <= '0;
      ue_addr  <= '0;
      ue_seen  <= 1'b0;
      ue_irq_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ue_irq_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (begin_pass) begin
            addr     <= '0;
            ce_count <= '0;
            ue_count <= '0;
            ue_addr  <= '0;
            ue_seen  <= 1'b0;
          end
        end
        ST_WAIT: if (mem_rvalid) rdata_q <= mem_rdata;
        ST_CHK: begin
          if (single_err) begin
            if (ce_count != '1) ce_count <= ce_count + 1'b1;
            wdata_q <= encode(corr_data);
          end else if (multi_err) begin
            if (ue_count != '1) ue_count <= ue_count + 1'b1;
            ue_irq_q <= 1'b1;
            if (!ue_seen) begin
              ue_addr <= addr;
              ue_seen <= 1'b1;
            end
          end
        end
        ST_NEXT: begin
          if (last_addr) done_q <= 1'b1;
          else           addr   <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign ue_irq    = ue_irq_q;
  assign mem_addr  = addr;
  assign mem_wdata = wdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ecc_mem_scrubber.sv
// Self-checking bench for ecc_mem_scrubber: memory responder with configurable
// grant/read latency, independent SECDED encoder and per-scenario tasks.
module tb_ecc_mem_scrubber;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 16;
  localparam int W     = AW + 39;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_req, mem_we, ue_irq;
  logic [AW-1:0] mem_addr, ue_addr;
  logic [38:0]   mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [38:0]   mem_rdata = '0;
  logic [CW-1:0] ce_count, ue_count;
  ecc_pkg::scrub_state_e dbg_state;

  ecc_mem_scrubber #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW), .INTERVAL(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ce_count(ce_count), .ue_count(ue_count), .ue_irq(ue_irq), .ue_addr(ue_addr),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [38:0] mem [DEPTH];
  logic [38:0] golden [DEPTH];

  int  rd_lat = 2, rd_delay = 0, wr_delay = 0;
  bit  rand_mode = 1'b0;
  int  wait_cnt = -1, rd_cnt = 0;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_log[$];
  logic [W-1:0]  wr_log[$];
  logic [W-1:0]  exp_q[$];
  int  irq_count = 0, done_count = 0, unstable_count = 0;
  int  cyc = 0, busy_rise_cyc = 0, done_cyc = 0;
  bit  held = 1'b0, busy_d = 1'b0;
  logic [AW-1:0] prev_addr;
  logic          prev_we;
  logic [38:0]   prev_wdata;

  // Textbook Hamming: data fills non-power-of-two positions 3..38 in order,
  // check bit i covers every position with bit i set; bit 38 is total parity.
  function automatic logic [38:0] tb_encode(input logic [31:0] d);
    logic [5:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < 6; i++) if (((p >> i) & 1) == 1) c[i] = c[i] ^ d[k];
        k++;
      end
    end
    return {^{c, d}, c, d};
  endfunction

  function automatic logic [38:0] bit_mask(input int b);
    logic [38:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  // Memory responder: all driving and sampling happens on the falling edge.
  always @(negedge clk) begin
    bit delivered;
    delivered = 1'b0;
    cyc++;
    mem_rvalid = 1'b0;
    mem_gnt = 1'b0;
    if (!rst_n) begin
      rd_cnt = 0; wait_cnt = -1; held = 1'b0; busy_d = 1'b0;
    end else begin
      if (busy && !busy_d) busy_rise_cyc = cyc;
      busy_d = busy;
      if (done) begin done_count++; done_cyc = cyc; end
      if (ue_irq) irq_count++;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = mem[rd_addr]; delivered = 1'b1;
        end
      end
      if (mem_req) begin
        if (held && (mem_addr !== prev_addr || mem_we !== prev_we ||
                     (mem_we && mem_wdata !== prev_wdata))) unstable_count++;
        if (wait_cnt < 0) wait_cnt = rand_mode ? $urandom_range(0, 3) : (mem_we ? wr_delay : rd_delay);
        if (wait_cnt == 0) begin
          mem_gnt = 1'b1; wait_cnt = -1; held = 1'b0;
          if (mem_we) begin
            wr_log.push_back({mem_addr, mem_wdata});
            mem[mem_addr] = mem_wdata;
          end else begin
            rd_log.push_back(mem_addr);
            rd_addr = mem_addr;
            rd_cnt = rd_lat;
          end
        end else begin
          wait_cnt--; held = 1'b1;
          prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
        end
      end else begin
        if (held) unstable_count++;
        held = 1'b0;
        if (rand_mode) begin
          mem_gnt = 1'($urandom_range(0, 1));
          if (rd_cnt == 0 && !delivered && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = 39'({$urandom(), $urandom()});
          end
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int dc0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done_count > dc0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic fill_clean();
    for (int a = 0; a < DEPTH; a++) begin
      golden[a] = tb_encode($urandom());
      mem[a] = golden[a];
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); exp_q.delete();
    irq_count = 0; unstable_count = 0;
  endtask

  task automatic check_writes(input string name);
    checks++;
    if (wr_log.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", name, wr_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_log[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s write %0d: got %h expected %h", name, i, wr_log[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, mem_req, mem_we, ue_irq} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, mem_req, mem_we, ue_irq});
    end
    checks++;
    if (mem_addr !== '0 || ue_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_addr_data: got addr %h ue_addr %h wdata %h expected 0", mem_addr, ue_addr, mem_wdata);
    end
    checks++;
    if (ce_count !== '0 || ue_count !== '0) begin
      errors++; $display("FAIL reset_counts: got ce %0d ue %0d expected 0", ce_count, ue_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    bit ok;
    int dc0;
    fill_clean(); clear_logs();
    dc0 = done_count;
    do_start();
    wait_done(dc0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_done: got timeout expected done pulse"); end
    checks++;
    if (rd_log.size() !== DEPTH) begin
      errors++; $display("FAIL clean_reads: got %0d expected %0d", rd_log.size(), DEPTH);
    end else begin
      foreach (rd_log[i]) begin
        checks++;
        if (rd_log[i] !== AW'(i)) begin
          errors++; $display("FAIL clean_read_addr %0d: got %0d expected %0d", i, rd_log[i], i);
        end
      end
    end
    check_writes("clean");
    checks++;
    if (done_cyc - busy_rise_cyc < 78 || done_cyc - busy_rise_cyc > 82) begin
      errors++; $display("FAIL clean_latency: got %0d expected 80 +-2", done_cyc - busy_rise_cyc);
    end
    checks++;
    if (ce_count !== '0 || ue_count !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL clean_status: got ce %0d ue %0d busy %b expected 0 0 0", ce_count, ue_count, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    int dc0;
    clear_logs();
    mem[3] = golden[3] ^ bit_mask(5);
    exp_q.push_back({4'd3, golden[3]});
    dc0 = done_count;
    do_start();
    wait_done(dc0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got timeout expected done pulse"); end
    check_writes("single");
    checks++;
    if (ce_count !== 16'd1 || ue_count !== 16'd0 || irq_count !== 0) begin
      errors++; $display("FAIL single_counts: got ce %0d ue %0d irq %0d expected 1 0 0", ce_count, ue_count, irq_count);
    end
    clear_logs();
    dc0 = done_count;
    do_start();
    wait_done(dc0, ok);
    check_writes("rescrub");
    checks++;
    if (!ok || ce_count !== 16'd0) begin
      errors++; $display("FAIL rescrub_ce: got ce %0d done %b expected 0 1", ce_count, ok);
    end
  endtask

  task automatic test_double();
    bit ok;
    int dc0;
    clear_logs();
    mem[9] = golden[9] ^ bit_mask(0) ^ bit_mask(7);
    dc0 = done_count;
    do_start();
    wait_done(dc0, ok);
    check_writes("double");
    checks++;
    if (!ok || irq_count !== 1 || ue_count !== 16'd1 || ue_addr !== 4'd9 || ce_count !== 16'd0) begin
      errors++;
      $display("FAIL double_status: got irq %0d ue %0d ue_addr %0d ce %0d expected 1 1 9 0",
               irq_count, ue_count, ue_addr, ce_count);
    end
    mem[9] = golden[9];
  endtask

  task automatic test_write_stall();
    bit ok;
    int dc0;
    clear_logs();
    wr_delay = 5;
    mem[6] = golden[6] ^ bit_mask(20);
    exp_q.push_back({4'd6, golden[6]});
    dc0 = done_count;
    do_start();
    wait_done(dc0, ok);
    wr_delay = 0;
    check_writes("stall");
    checks++;
    if (!ok || unstable_count !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d changes done %b expected 0 1", unstable_count, ok);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int dc0;
    clear_logs();
    dc0 = done_count;
    do_start();
    repeat (10) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done(dc0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_done: got timeout expected done pulse"); end
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b expected 1", busy); end
    wait_done(dc0 + 1, ok);
    checks++;
    if (!ok || rd_log.size() !== 2 * DEPTH || done_count !== dc0 + 2) begin
      errors++;
      $display("FAIL b2b_reads: got %0d reads %0d dones expected %0d %0d", rd_log.size(), done_count - dc0, 2 * DEPTH, 2);
    end else begin
      foreach (rd_log[i]) begin
        checks++;
        if (rd_log[i] !== AW'(i % DEPTH)) begin
          errors++; $display("FAIL b2b_read_addr %0d: got %0d expected %0d", i, rd_log[i], i % DEPTH);
        end
      end
    end
    checks++;
    if (done_cyc - busy_rise_cyc < 78 || done_cyc - busy_rise_cyc > 82) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 80 +-2", done_cyc - busy_rise_cyc);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit seen;
    int dc0;
    clear_logs();
    wr_delay = 100;
    mem[2] = golden[2] ^ bit_mask(33);
    do_start();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (mem_req && mem_we) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_wr_reach: got timeout expected write request"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_req, mem_we, ue_irq} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        ce_count !== '0 || ue_count !== '0 || ue_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid_write: got flags %b addr %h wdata %h ce %0d expected all 0",
               {busy, done, mem_req, mem_we, ue_irq}, mem_addr, mem_wdata, ce_count);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wr_delay = 0;
    clear_logs();
    exp_q.push_back({4'd2, golden[2]});
    dc0 = done_count;
    do_start();
    wait_done(dc0, ok);
    checks++;
    if (!ok || rd_log.size() == 0 || rd_log[0] !== '0) begin
      errors++; $display("FAIL rst_restart: got done %b first read %0d expected 1 0", ok,
                         rd_log.size() == 0 ? -1 : int'(rd_log[0]));
    end
    check_writes("rst_restart");
    checks++;
    if (ce_count !== 16'd1) begin errors++; $display("FAIL rst_restart_ce: got %0d expected 1", ce_count); end
  endtask

  task automatic test_random();
    bit ok;
    int dc0, kind, b1, b2, exp_ce, exp_ue;
    logic [AW-1:0] exp_ua;
    bit first;
    logic [38:0] exp_mem [DEPTH];
    for (int pass = 0; pass < 4; pass++) begin
      clear_logs();
      rand_mode = 1'b1;
      rd_lat = $urandom_range(1, 4);
      exp_ce = 0; exp_ue = 0; exp_ua = '0; first = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
        kind = $urandom_range(0, 5);
        exp_mem[a] = golden[a];
        mem[a] = golden[a];
        if (kind == 3 || kind == 4) begin
          b1 = (kind == 3) ? $urandom_range(0, 31) : $urandom_range(32, 38);
          mem[a] = golden[a] ^ bit_mask(b1);
          exp_q.push_back({AW'(a), golden[a]});
          exp_ce++;
        end else if (kind == 5) begin
          b1 = $urandom_range(0, 38);
          b2 = (b1 + $urandom_range(1, 38)) % 39;
          mem[a] = golden[a] ^ bit_mask(b1) ^ bit_mask(b2);
          exp_mem[a] = mem[a];
          exp_ue++;
          if (first) begin exp_ua = AW'(a); first = 1'b0; end
        end
      end
      dc0 = done_count;
      do_start();
      wait_done(dc0, ok);
      checks++;
      if (!ok || rd_log.size() !== DEPTH) begin
        errors++; $display("FAIL rand_pass%0d: got done %b reads %0d expected 1 %0d", pass, ok, rd_log.size(), DEPTH);
      end
      check_writes("rand");
      checks++;
      if (ce_count !== CW'(exp_ce) || ue_count !== CW'(exp_ue) || ue_addr !== exp_ua || irq_count !== exp_ue) begin
        errors++;
        $display("FAIL rand_status%0d: got ce %0d ue %0d ua %0d irq %0d expected %0d %0d %0d %0d",
                 pass, ce_count, ue_count, ue_addr, irq_count, exp_ce, exp_ue, exp_ua, exp_ue);
      end
      for (int a = 0; a < DEPTH; a++) begin
        checks++;
        if (mem[a] !== exp_mem[a]) begin
          errors++; $display("FAIL rand_mem%0d[%0d]: got %h expected %h", pass, a, mem[a], exp_mem[a]);
        end
        mem[a] = golden[a];
      end
    end
    rand_mode = 1'b0;
    rd_lat = 2;
  endtask

`ifdef ECC_SCRUB_AUTO_EN
  task automatic test_auto();
    bit ok;
    bit seen;
    int dc0;
    dc0 = done_count;
    do_start();
    wait_done(dc0, ok);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (busy_rise_cyc > done_cyc) begin seen = 1'b1; break; end
    end
    checks++;
    if (!ok || !seen || busy_rise_cyc - done_cyc < 20 || busy_rise_cyc - done_cyc > 21) begin
      errors++; $display("FAIL auto_pass: got gap %0d seen %b expected 20..21", busy_rise_cyc - done_cyc, seen);
    end
    dc0 = done_count;
    wait_done(dc0, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_write_stall();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
`ifdef ECC_SCRUB_AUTO_EN
    test_auto();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
